// File: rtl/serial_adder_if.sv
// rtl/serial_adder_if.sv - handshake and result bundle for the bit-serial adder
//
// Ports (master = requester, slave = adder):
//   start  master->slave  request to begin an addition
//   a, b   master->slave  WIDTH-bit operands, captured on the accepting edge
//   busy   slave->master  high while an addition is in flight
//   done   slave->master  one-cycle pulse, sum/carry valid
//   sum    slave->master  WIDTH-bit result, held until the next result
//   carry  slave->master  carry out of the top bit, held with sum
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry;

    modport master (
        output start, a, b,
        input  busy, done, sum, carry
    );

    modport slave (
        input  start, a, b,
        output busy, done, sum, carry
    );
endinterface

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial WIDTH-bit adder built on one full-adder slice
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    serial_adder_if.slave: start/a/b in, busy/done/sum/carry out
//
// One bit is added per RUN cycle, LSB first. The result word is filled from
// the top so that after WIDTH shifts bit 0 of the operands lands in bit 0.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    serial_adder_if.slave bus
);
    localparam int              CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [WIDTH-1:0] rs;
    logic [WIDTH-1:0] rs_nx;
    logic             cf;
    logic [CW-1:0]    cnt;

    // Full-adder slice as two half adders plus an OR.
    logic x, y, h1s, h1c, s, h2c, cout;
    assign x    = ra[0];
    assign y    = rb[0];
    assign h1s  = x ^ y;
    assign h1c  = x & y;
    assign s    = h1s ^ cf;
    assign h2c  = h1s & cf;
    assign cout = h1c | h2c;

    // WIDTH=1 has no upper bits to keep, so the new bit is the whole word.
    generate
        if (WIDTH == 1) begin : g_rs_w1
            assign rs_nx = s;
        end else begin : g_rs_wn
            assign rs_nx = {s, rs[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        bus.busy = 1'b0;
        bus.done = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                bus.busy = 1'b1;
                if (cnt == LAST) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                bus.busy = 1'b1;
                bus.done = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ra        <= '0;
            rb        <= '0;
            rs        <= '0;
            cf        <= 1'b0;
            cnt       <= '0;
            bus.sum   <= '0;
            bus.carry <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        ra  <= bus.a;
                        rb  <= bus.b;
                        rs  <= '0;
                        cf  <= 1'b0;
                        cnt <= '0;
                    end
                end
                RUN: begin
                    cf  <= cout;
                    ra  <= ra >> 1;
                    rb  <= rb >> 1;
                    rs  <= rs_nx;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        bus.sum   <= rs_nx;
                        bus.carry <= cout;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed self-checking bench for serial_adder
module tb_serial_adder;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    serial_adder_if #(.WIDTH(8)) bus8 ();
    serial_adder_if #(.WIDTH(1)) bus1 ();

    serial_adder #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b1;
        bus8.start = 1'b0; bus8.a = '0; bus8.b = '0;
        bus1.start = 1'b0; bus1.a = '0; bus1.b = '0;
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus8.busy !== 1'b0 || bus8.done !== 1'b0 || bus8.sum !== 8'h00 || bus8.carry !== 1'b0) begin
            failures++;
            $display("FAIL reset_state got busy=%b done=%b sum=%h carry=%b exp 0/0/00/0",
                     bus8.busy, bus8.done, bus8.sum, bus8.carry);
        end
        tick(); tick();
        #2 rst_n = 1'b1;
        tick();
        checks++;
        if (bus8.busy !== 1'b0 || bus8.done !== 1'b0) begin
            failures++;
            $display("FAIL reset_release got busy=%b done=%b exp 0/0", bus8.busy, bus8.done);
        end
    endtask

    task automatic test_zero;
        int nb;
        int nd;
        int at;
        bus8.a = 8'h00; bus8.b = 8'h00; bus8.start = 1'b1;
        tick();
        bus8.start = 1'b0;
        nb = 0; nd = 0; at = -1;
        for (int k = 0; k < 12; k++) begin
            if (bus8.busy === 1'b1) nb++;
            if (bus8.done === 1'b1) begin
                nd++;
                at = k;
                checks++;
                if (bus8.sum !== 8'h00 || bus8.carry !== 1'b0) begin
                    failures++;
                    $display("FAIL zero_result got sum=%h carry=%b exp 00/0", bus8.sum, bus8.carry);
                end
            end
            tick();
        end
        checks++;
        if (nb != 9) begin
            failures++;
            $display("FAIL zero_busy_cycles got %0d exp 9", nb);
        end
        checks++;
        if (nd != 1 || at != 8) begin
            failures++;
            $display("FAIL zero_done_pulse got count=%0d at=E%0d exp count=1 at=E8", nd, at);
        end
    endtask

    task automatic test_add_5a33;
        bus8.a = 8'h5A; bus8.b = 8'h33; bus8.start = 1'b1;
        tick();
        bus8.start = 1'b0;
        for (int k = 0; k <= 9; k++) begin
            checks++;
            if (bus8.busy !== (k <= 8) || bus8.done !== (k == 8)) begin
                failures++;
                $display("FAIL add5a33_timing E%0d got busy=%b done=%b exp busy=%b done=%b",
                         k, bus8.busy, bus8.done, (k <= 8), (k == 8));
            end
            if (k == 8) begin
                checks++;
                if (bus8.sum !== 8'h8D || bus8.carry !== 1'b0) begin
                    failures++;
                    $display("FAIL add5a33_result got sum=%h carry=%b exp 8d/0", bus8.sum, bus8.carry);
                end
            end
            if (k < 9) tick();
        end
    endtask

    task automatic test_carry_chain;
        logic [7:0] va [2];
        logic [7:0] vb [2];
        logic [7:0] vs [2];
        logic       vc [2];
        int         at;
        va[0] = 8'hFF; vb[0] = 8'h01; vs[0] = 8'h00; vc[0] = 1'b1;
        va[1] = 8'hFF; vb[1] = 8'hFF; vs[1] = 8'hFE; vc[1] = 1'b1;
        for (int v = 0; v < 2; v++) begin
            tick();
            bus8.a = va[v]; bus8.b = vb[v]; bus8.start = 1'b1;
            tick();
            bus8.start = 1'b0;
            at = -1;
            for (int k = 0; k < 12 && at < 0; k++) begin
                if (bus8.done === 1'b1) at = k;
                else tick();
            end
            checks++;
            if (at != 8 || bus8.sum !== vs[v] || bus8.carry !== vc[v]) begin
                failures++;
                $display("FAIL carry_chain[%0d] got at=E%0d sum=%h carry=%b exp at=E8 sum=%h carry=%b",
                         v, at, bus8.sum, bus8.carry, vs[v], vc[v]);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back;
        tick();
        bus8.a = 8'h5A; bus8.b = 8'h33; bus8.start = 1'b1;
        tick();
        bus8.a = 8'h11; bus8.b = 8'h11;
        for (int k = 1; k <= 18; k++) begin
            tick();
            if (k == 8) begin
                checks++;
                if (bus8.done !== 1'b1 || bus8.sum !== 8'h8D || bus8.carry !== 1'b0) begin
                    failures++;
                    $display("FAIL ignore_first got done=%b sum=%h carry=%b exp 1/8d/0",
                             bus8.done, bus8.sum, bus8.carry);
                end
            end else if (k == 9) begin
                checks++;
                if (bus8.busy !== 1'b0 || bus8.done !== 1'b0) begin
                    failures++;
                    $display("FAIL ignore_idle_E9 got busy=%b done=%b exp 0/0", bus8.busy, bus8.done);
                end
            end else if (k == 10) begin
                checks++;
                if (bus8.busy !== 1'b1) begin
                    failures++;
                    $display("FAIL ignore_accept_E10 got busy=%b exp 1", bus8.busy);
                end
                bus8.start = 1'b0;
            end else if (k == 18) begin
                checks++;
                if (bus8.done !== 1'b1 || bus8.sum !== 8'h22 || bus8.carry !== 1'b0) begin
                    failures++;
                    $display("FAIL ignore_second got done=%b sum=%h carry=%b exp 1/22/0",
                             bus8.done, bus8.sum, bus8.carry);
                end
            end else if (bus8.done !== 1'b0) begin
                checks++;
                failures++;
                $display("FAIL ignore_stray_done E%0d got done=%b exp 0", k, bus8.done);
            end
        end
        tick();
    endtask

    task automatic test_reset_mid;
        int at;
        tick();
        bus8.a = 8'h5A; bus8.b = 8'h33; bus8.start = 1'b1;
        tick();
        bus8.start = 1'b0;
        for (int k = 1; k <= 4; k++) tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus8.busy !== 1'b0 || bus8.done !== 1'b0 || bus8.sum !== 8'h00 || bus8.carry !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid got busy=%b done=%b sum=%h carry=%b exp 0/0/00/0",
                     bus8.busy, bus8.done, bus8.sum, bus8.carry);
        end
        #2 rst_n = 1'b1;
        tick();
        checks++;
        if (bus8.busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_idle got busy=%b exp 0", bus8.busy);
        end
        bus8.a = 8'h01; bus8.b = 8'h02; bus8.start = 1'b1;
        tick();
        bus8.start = 1'b0;
        at = -1;
        for (int k = 0; k < 12 && at < 0; k++) begin
            if (bus8.done === 1'b1) at = k;
            else tick();
        end
        checks++;
        if (at != 8 || bus8.sum !== 8'h03 || bus8.carry !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_after got at=E%0d sum=%h carry=%b exp at=E8 sum=03 carry=0",
                     at, bus8.sum, bus8.carry);
        end
        tick();
    endtask

    task automatic test_width1;
        tick();
        bus1.a = 1'b1; bus1.b = 1'b1; bus1.start = 1'b1;
        tick();
        bus1.start = 1'b0;
        checks++;
        if (bus1.busy !== 1'b1 || bus1.done !== 1'b0) begin
            failures++;
            $display("FAIL w1_E0 got busy=%b done=%b exp 1/0", bus1.busy, bus1.done);
        end
        tick();
        checks++;
        if (bus1.done !== 1'b1 || bus1.sum !== 1'b0 || bus1.carry !== 1'b1) begin
            failures++;
            $display("FAIL w1_E1 got done=%b sum=%b carry=%b exp 1/0/1", bus1.done, bus1.sum, bus1.carry);
        end
        tick();
        checks++;
        if (bus1.busy !== 1'b0 || bus1.done !== 1'b0) begin
            failures++;
            $display("FAIL w1_E2 got busy=%b done=%b exp 0/0", bus1.busy, bus1.done);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_zero();
        test_add_5a33();
        test_carry_chain();
        test_back_to_back();
        test_reset_mid();
        test_width1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
